// File: rtl/power_decode_unit.sv
// Single-stage registered decoder for A/B/D-format POWER instructions.
// Instruction bit 0 is the MSB (instruction_i[31]); bodyOut fields are packed LSB-first, e.g. FRT = bodyOut[4:0].
module power_decode_unit #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regAccessPatternSize    = 2,
    parameter int funcUnitCodeSize        = 3,
    parameter int A                       = 512,
    parameter int B                       = 2,
    parameter int D                       = 32
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    output logic                               enableOut,
    output logic [24:0]                        instFormat_o,
    output logic [opcodeSize-1:0]              opcodeOut,
    output logic [addressWidth-1:0]            addressOut,
    output logic [funcUnitCodeSize-1:0]        funcUnitTypeOut,
    output logic [instructionCounterWidth-1:0] majIDOut,
    output logic [instMinIdWidth-1:0]          minIDOut,
    output logic                               is64BitOut,
    output logic [PidSize-1:0]                 pidOut,
    output logic [TidSize-1:0]                 tidOut,
    output logic [regAccessPatternSize-1:0]    op1rwOut,
    output logic [regAccessPatternSize-1:0]    op2rwOut,
    output logic [regAccessPatternSize-1:0]    op3rwOut,
    output logic [regAccessPatternSize-1:0]    op4rwOut,
    output logic                               op1IsRegOut,
    output logic                               op2IsRegOut,
    output logic                               op3IsRegOut,
    output logic                               op4IsRegOut,
    output logic [83:0]                        bodyOut
);

    localparam int formatWidth = 25;
    localparam int bodyWidth   = 84;

    localparam logic [regAccessPatternSize-1:0] rwNone  = 2'b00;
    localparam logic [regAccessPatternSize-1:0] rwRead  = 2'b01;
    localparam logic [regAccessPatternSize-1:0] rwWrite = 2'b10;
    localparam logic [regAccessPatternSize-1:0] rwBoth  = 2'b11;

    localparam logic [funcUnitCodeSize-1:0] unitInt    = 3'd0;
    localparam logic [funcUnitCodeSize-1:0] unitFpu    = 3'd1;
    localparam logic [funcUnitCodeSize-1:0] unitBranch = 3'd2;
    localparam logic [funcUnitCodeSize-1:0] unitLdSt   = 3'd3;

    typedef struct packed {
        logic                                      valid;
        logic [formatWidth-1:0]                    format;
        logic [opcodeSize-1:0]                     opcode;
        logic [funcUnitCodeSize-1:0]               unit;
        logic [3:0][regAccessPatternSize-1:0]      rw;
        logic [3:0]                                isReg;
        logic [bodyWidth-1:0]                      body;
    } decodeT;

    typedef struct packed {
        logic [addressWidth-1:0]            address;
        logic [instructionCounterWidth-1:0] majId;
        logic                               is64Bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
    } tagT;

    decodeT decNext, decReg;
    tagT    tagNext, tagReg;

    logic [5:0]  primary;
    logic [4:0]  xo;
    logic [15:0] dField;
    logic        aXo, isA, isB, isD;
    logic        dCmp, dLogical, dLdSt, dUpdate, dLoad, dZeroExt, dShifted;
    logic [5:0]  dBase;
    logic [31:0] imm32;
    logic [63:0] imm64;

    // POWER bit n lives at instruction_i[31-n]
    assign primary = instruction_i[31:26];
    assign xo      = instruction_i[5:1];
    assign dField  = instruction_i[15:0];

    always_comb begin
        aXo = 1'b0;
        case (xo)
            5'd18, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25,
            5'd26, 5'd28, 5'd29, 5'd30, 5'd31: aXo = 1'b1;
            default: aXo = 1'b0;
        endcase
    end

    assign isA = ((primary == 6'd59) && aXo) ||
                 ((primary == 6'd63) && (aXo || (xo == 5'd23)));
    assign isB = (primary == 6'd16);

    assign dCmp     = (primary == 6'd2) || (primary == 6'd3) ||
                      (primary == 6'd10) || (primary == 6'd11);
    assign dLogical = (primary >= 6'd24) && (primary <= 6'd29);
    assign dLdSt    = (primary >= 6'd32) && (primary <= 6'd55);

    always_comb begin
        isD = 1'b0;
        case (primary)
            6'd2, 6'd3, 6'd7, 6'd8, 6'd10, 6'd11,
            6'd12, 6'd13, 6'd14, 6'd15: isD = 1'b1;
            default: isD = dLogical || dLdSt;
        endcase
    end

    // stmw (47) is odd but not an update form; the rest of the odd ld/st ops update RA
    assign dUpdate = dLdSt && primary[0] && (primary != 6'd47);
    assign dBase   = dUpdate ? {primary[5:1], 1'b0} : primary;

    always_comb begin
        dLoad = 1'b0;
        case (dBase)
            6'd32, 6'd34, 6'd40, 6'd42, 6'd46, 6'd48, 6'd50: dLoad = 1'b1;
            default: dLoad = 1'b0;
        endcase
    end

    assign dZeroExt = (primary == 6'd10) || dLogical;
    assign dShifted = (primary == 6'd15) || (primary == 6'd25) ||
                      (primary == 6'd27) || (primary == 6'd29);
    assign imm32    = dShifted ? {dField, 16'h0000}
                               : {{16{~dZeroExt & dField[15]}}, dField};
    assign imm64    = {{32{~dZeroExt & imm32[31]}}, imm32};

    always_comb begin
        decNext = '0;
        if (isA) begin
            decNext.valid      = 1'b1;
            decNext.format     = formatWidth'(A);
            decNext.opcode     = {primary, 1'b0, xo};
            decNext.unit       = unitFpu;
            decNext.body[4:0]  = instruction_i[25:21];
            decNext.body[9:5]  = instruction_i[20:16];
            decNext.body[14:10] = instruction_i[15:11];
            decNext.body[19:15] = instruction_i[10:6];
            decNext.body[20]   = instruction_i[0];
            decNext.rw         = {rwRead, rwRead, rwRead, rwWrite};
            decNext.isReg      = 4'b1111;
            // single/two-source forms leave FRA, FRB or FRC unused
            if (xo == 5'd18 || xo == 5'd20 || xo == 5'd21) begin
                decNext.rw[3] = rwNone; decNext.isReg[3] = 1'b0;
            end
            if (xo == 5'd25) begin
                decNext.rw[2] = rwNone; decNext.isReg[2] = 1'b0;
            end
            if (xo == 5'd22 || xo == 5'd24 || xo == 5'd26) begin
                decNext.rw[1] = rwNone; decNext.isReg[1] = 1'b0;
                decNext.rw[3] = rwNone; decNext.isReg[3] = 1'b0;
            end
        end else if (isB) begin
            decNext.valid       = 1'b1;
            decNext.format      = formatWidth'(B);
            decNext.opcode      = {primary, 6'd0};
            decNext.unit        = unitBranch;
            decNext.body[4:0]   = instruction_i[25:21];
            decNext.body[9:5]   = instruction_i[20:16];
            decNext.body[23:10] = instruction_i[15:2];
            decNext.body[24]    = instruction_i[1];
            decNext.body[25]    = instruction_i[0];
        end else if (isD) begin
            decNext.valid       = 1'b1;
            decNext.format      = formatWidth'(D);
            decNext.opcode      = {primary, 6'd0};
            decNext.unit        = dLdSt ? unitLdSt : unitInt;
            decNext.body[4:0]   = instruction_i[25:21];
            decNext.body[9:5]   = instruction_i[20:16];
            decNext.body[83:20] = imm64;
            decNext.isReg       = {2'b00, 1'b1, ~dCmp};
            if (dCmp) begin
                decNext.rw[0] = rwNone;
                decNext.rw[1] = rwRead;
            end else if (dLogical) begin
                decNext.rw[0] = rwRead;
                decNext.rw[1] = rwWrite;
            end else if (dLdSt) begin
                decNext.rw[0] = dLoad ? rwWrite : rwRead;
                decNext.rw[1] = dUpdate ? rwBoth : rwRead;
            end else begin
                decNext.rw[0] = rwWrite;
                decNext.rw[1] = rwRead;
            end
        end
    end

    assign tagNext = '{address: instructionAddress_i, majId: instructionMajId_i,
                       is64Bit: is64Bit_i, pid: instructionPid_i, tid: instructionTid_i};

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            decReg <= '0;
            tagReg <= '0;
        end else if (!stall_i) begin
            if (enable_i) begin
                decReg <= decNext;
                tagReg <= tagNext;
            end else begin
                decReg <= '0;
                tagReg <= '0;
            end
        end
    end

    assign enableOut       = decReg.valid;
    assign instFormat_o    = decReg.format;
    assign opcodeOut       = decReg.opcode;
    assign funcUnitTypeOut = decReg.unit;
    assign op1rwOut        = decReg.rw[0];
    assign op2rwOut        = decReg.rw[1];
    assign op3rwOut        = decReg.rw[2];
    assign op4rwOut        = decReg.rw[3];
    assign op1IsRegOut     = decReg.isReg[0];
    assign op2IsRegOut     = decReg.isReg[1];
    assign op3IsRegOut     = decReg.isReg[2];
    assign op4IsRegOut     = decReg.isReg[3];
    assign bodyOut         = decReg.body;
    assign addressOut      = tagReg.address;
    assign majIDOut        = tagReg.majId;
    assign is64BitOut      = tagReg.is64Bit;
    assign pidOut          = tagReg.pid;
    assign tidOut          = tagReg.tid;
    assign minIDOut        = '0;

endmodule

// File: tb/tb_power_decode_unit.sv
// Directed + randomized bench for power_decode_unit against a rule-level decode model.
module tb_power_decode_unit;
    logic        clk = 1'b0, rstN = 1'b0, en = 1'b0, stall = 1'b0, is64 = 1'b0;
    logic [31:0] ins = '0;
    logic [63:0] addr = '0, majId = '0;
    logic [19:0] pid = '0;
    logic [15:0] tid = '0;

    logic        enableOut, is64BitOut;
    logic [24:0] instFormat_o;
    logic [11:0] opcodeOut;
    logic [63:0] addressOut, majIDOut;
    logic [2:0]  funcUnitTypeOut;
    logic [6:0]  minIDOut;
    logic [19:0] pidOut;
    logic [15:0] tidOut;
    logic [1:0]  op1rwOut, op2rwOut, op3rwOut, op4rwOut;
    logic        op1IsRegOut, op2IsRegOut, op3IsRegOut, op4IsRegOut;
    logic [83:0] bodyOut;

    power_decode_unit dut (
        .clock_i(clk), .reset_i(rstN), .enable_i(en), .stall_i(stall),
        .instruction_i(ins), .instructionAddress_i(addr), .is64Bit_i(is64),
        .instructionPid_i(pid), .instructionTid_i(tid), .instructionMajId_i(majId),
        .enableOut(enableOut), .instFormat_o(instFormat_o), .opcodeOut(opcodeOut),
        .addressOut(addressOut), .funcUnitTypeOut(funcUnitTypeOut), .majIDOut(majIDOut),
        .minIDOut(minIDOut), .is64BitOut(is64BitOut), .pidOut(pidOut), .tidOut(tidOut),
        .op1rwOut(op1rwOut), .op2rwOut(op2rwOut), .op3rwOut(op3rwOut), .op4rwOut(op4rwOut),
        .op1IsRegOut(op1IsRegOut), .op2IsRegOut(op2IsRegOut),
        .op3IsRegOut(op3IsRegOut), .op4IsRegOut(op4IsRegOut), .bodyOut(bodyOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [24:0] fmt;
        logic [11:0] opc;
        logic [2:0]  unit;
        logic [7:0]  rw;     // {op4,op3,op2,op1}
        logic [3:0]  isReg;  // {op4,op3,op2,op1}
        logic [83:0] body;
    } expT;

    typedef struct packed {
        logic [63:0] address;
        logic [63:0] majId;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [6:0]  minId;
    } tagT;

    localparam logic [1:0] R = 2'b01, W = 2'b10, RW = 2'b11;

    int tests = 0, failed = 0;
    int aHits, bHits, dHits;
    logic [511:0] allOut;
    expT  obsDec, e, held;
    tagT  obsTag, heldTag;
    logic [31:0] instr;

    assign allOut = {enableOut, instFormat_o, opcodeOut, addressOut, funcUnitTypeOut, majIDOut,
                     minIDOut, is64BitOut, pidOut, tidOut, op1rwOut, op2rwOut, op3rwOut, op4rwOut,
                     op1IsRegOut, op2IsRegOut, op3IsRegOut, op4IsRegOut, bodyOut};
    assign obsDec = {enableOut, instFormat_o, opcodeOut, funcUnitTypeOut,
                     {op4rwOut, op3rwOut, op2rwOut, op1rwOut},
                     {op4IsRegOut, op3IsRegOut, op2IsRegOut, op1IsRegOut}, bodyOut};
    assign obsTag = {addressOut, majIDOut, is64BitOut, pidOut, tidOut, minIDOut};

    function automatic expT model(input logic [31:0] i);
        expT r = '0;
        int p = int'(i[31:26]);
        int x = int'(i[5:1]);
        logic [1:0] o1, o2, o3, o4;
        longint imm;
        logic [63:0] immU;
        logic [15:0] d = i[15:0];
        if ((p == 59 && x inside {18,20,21,22,24,25,26,28,29,30,31}) ||
            (p == 63 && x inside {18,20,21,22,23,24,25,26,28,29,30,31})) begin
            r.en = 1; r.fmt = 25'd512; r.opc = 12'(p * 64 + x); r.unit = 3'd1;
            r.body = 84'((i >> 21) & 32'd31) | (84'((i >> 16) & 32'd31) << 5) |
                     (84'((i >> 11) & 32'd31) << 10) | (84'((i >> 6) & 32'd31) << 15) |
                     (84'(i & 32'd1) << 20);
            o2 = (x inside {22,24,26}) ? 2'b00 : R;
            o3 = (x == 25) ? 2'b00 : R;
            o4 = (x inside {18,20,21,22,24,26}) ? 2'b00 : R;
            r.rw = {o4, o3, o2, W};
            r.isReg = {o4 != 0, o3 != 0, o2 != 0, 1'b1};
        end else if (p == 16) begin
            r.en = 1; r.fmt = 25'd2; r.opc = 12'(16 * 64); r.unit = 3'd2;
            r.body = 84'((i >> 21) & 32'd31) | (84'((i >> 16) & 32'd31) << 5) |
                     (84'((i >> 2) & 32'h3FFF) << 10) | (84'((i >> 1) & 32'd1) << 24) |
                     (84'(i & 32'd1) << 25);
        end else if (p inside {2,3,7,8,[10:15],[24:29],[32:55]}) begin
            r.en = 1; r.fmt = 25'd32; r.opc = 12'(p * 64); r.unit = (p >= 32) ? 3'd3 : 3'd0;
            if (p == 10 || p inside {[24:29]}) imm = longint'({48'd0, d});
            else imm = longint'($signed(d));
            if (p inside {15,25,27,29}) imm = imm * 65536;
            immU = imm;
            r.body = 84'((i >> 21) & 32'd31) | (84'((i >> 16) & 32'd31) << 5) | (84'(immU) << 20);
            if (p inside {32,34,40,42,46,48,50}) begin o1 = W; o2 = R; end
            else if (p inside {36,38,44,47,52,54}) begin o1 = R; o2 = R; end
            else if (p % 2 == 1 && p >= 33) begin
                o1 = ((p - 1) inside {32,34,40,42,46,48,50}) ? W : R;
                o2 = RW;
            end
            else if (p inside {7,8,12,13,14,15}) begin o1 = W; o2 = R; end
            else if (p inside {[24:29]}) begin o1 = R; o2 = W; end
            else begin o1 = 2'b00; o2 = R; end
            r.rw = {4'b0000, o2, o1};
            r.isReg = {2'b00, 1'b1, o1 != 0};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e_en, input logic [31:0] i);
        en = e_en; ins = i;
        addr = {$urandom, $urandom}; majId = {$urandom, $urandom};
        pid = 20'($urandom); tid = 16'($urandom); is64 = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic checkDec(input string tag);
        expT  x = model(ins);
        tagT  t = {addr, majId, is64, pid, tid, 7'd0};
        if (!en) check({tag, "_off"}, {enableOut, instFormat_o}, '0);
        else begin
            if (x.en) check(tag, obsDec, x);
            else check({tag, "_unrec"}, {enableOut, instFormat_o, bodyOut}, '0);
            check({tag, "_tag"}, obsTag, t);
        end
    endtask

    initial begin
        // reset with live inputs
        step(1, 32'hFC00002A);
        step(1, 32'h3860FFFF);
        check("reset_init", allOut, '0);
        rstN = 1'b1;
        step(0, 32'hFC00002A);
        check("reset_rel_en", {enableOut, instFormat_o}, '0);

        step(1, 32'hFC00002A);
        check("fadd_opc", opcodeOut, {6'd63, 6'd21});
        check("fadd_unit", funcUnitTypeOut, 3'd1);
        check("fadd_fmt", instFormat_o, 25'd512);
        checkDec("fadd");

        step(1, 32'h3860FFFF);
        check("addi_imm", bodyOut[83:20], 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_op1rw", op1rwOut, 2'b10);
        checkDec("addi");

        en = 1; ins = 32'h3860FFFF; addr = 64'h1000; majId = 64'd7; pid = 20'd3; tid = 16'd2; is64 = 1;
        @(posedge clk); #1;
        check("pt_addr", addressOut, 64'h1000);
        check("pt_maj", majIDOut, 64'd7);
        check("pt_pid", pidOut, 20'd3);
        check("pt_tid", tidOut, 16'd2);
        check("pt_min", minIDOut, 7'd0);

        step(1, {6'd16, 26'h2ABCDEF});
        check("bc_opc", opcodeOut, {6'd16, 6'd0});
        check("bc_fmt", instFormat_o, 25'd2);
        check("bc_unit", funcUnitTypeOut, 3'd2);

        aHits = 0;
        for (int p = 0; p < 64; p++)
            for (int x = 0; x < 32; x++) begin
                instr = $urandom; instr[31:26] = p[5:0]; instr[5:1] = x[4:0];
                step(1, instr);
                checkDec("sweepA");
                if (enableOut && instFormat_o == 25'd512) aHits++;
            end
        check("countA", aHits, 23);

        bHits = 0; dHits = 0;
        for (int p = 0; p < 64; p++) begin
            instr = $urandom; instr[31:26] = p[5:0]; instr[5:1] = 5'd31;
            step(1, instr);
            checkDec("sweepBD");
            if (enableOut && instFormat_o == 25'd2) bHits++;
            if (enableOut && instFormat_o == 25'd32) dHits++;
        end
        check("countB", bHits, 1);
        check("countD", dHits, 40);

        // stall: outputs freeze on the last decoded instruction
        step(1, 32'hFC00002A);
        held = model(32'hFC00002A);
        heldTag = {addr, majId, is64, pid, tid, 7'd0};
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'($urandom), $urandom);
            check("stall_dec", obsDec, held);
            check("stall_tag", obsTag, heldTag);
        end
        stall = 1'b0;
        step(1, 32'h3860FFFF);
        checkDec("unstall");

        // asynchronous reset mid-operation
        rstN = 1'b0; #1;
        check("reset_async", allOut, '0);
        @(posedge clk); #1;
        check("reset_hold", allOut, '0);
        rstN = 1'b1;
        step(0, 32'h3860FFFF);
        check("reset_rel2", enableOut, 1'b0);

        for (int k = 0; k < 500; k++) begin
            instr = $urandom;
            if (k % 2 == 0) instr[31:26] = 6'($urandom_range(32, 63));
            step(($urandom_range(0, 3) != 0), instr);
            checkDec("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/power_decode_unit.md
Name: power_decode_unit

Overview:
- Single-stage, registered instruction decoder for the 64-bit POWER front end; sits between fetch and the issue/rename stages.
- Classifies each 32-bit instruction as A-, B- or D-format.
- Emits a one-hot format code, a compact opcode, the functional-unit class, operand register/access info and a packed operand body.
- Forwards the instruction's tag fields: address, IDs, mode.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major instruction ID width
- instMinIdWidth, 7, minor ID width
- opcodeSize, 12, compact opcode width
- regAccessPatternSize, 2, per-operand access field: [0] read, [1] written
- funcUnitCodeSize, 3, functional-unit code width
- A, 512, one-hot format code for A-format
- B, 2, one-hot format code for B-format
- D, 32, one-hot format code for D-format

Ports:
- clock_i in 1 clock, rising edge
- reset_i in 1 asynchronous active-low reset
- enable_i in 1 input instruction valid
- stall_i in 1 hold all outputs
- instruction_i in 32 instruction, bit 0 = MSB
- instructionAddress_i in 64 instruction address
- is64Bit_i in 1 64-bit mode
- instructionPid_i in 20 process ID
- instructionTid_i in 16 thread ID
- instructionMajId_i in 64 major ID
- enableOut out 1 valid decoded instruction
- instFormat_o out 25 one-hot format code (A/B/D values above)
- opcodeOut out 12 {primary[0:5], ext}; ext = {0, bits 26:30} for A-format, 0 otherwise
- addressOut out 64 registered address
- funcUnitTypeOut out 3 unit class: 0 integer, 1 FPU, 2 branch, 3 load/store
- majIDOut out 64 registered major ID
- minIDOut out 7 minor ID, always 0 (no cracking)
- is64BitOut out 1 registered mode
- pidOut out 20 registered process ID
- tidOut out 16 registered thread ID
- op1rwOut..op4rwOut out 2 each, operand access pattern
- op1IsRegOut..op4IsRegOut out 1 each, operand is a register
- bodyOut out 84 packed operands; unused bits 0

Behaviour:
- Reset: reset_i low asynchronously clears every output to 0.
- Latency: one cycle. Inputs sampled on a rising edge appear on outputs after that edge.
- stall_i high (priority over enable_i): all output registers hold.
- enable_i low: enableOut=0 and format=0 next cycle; other outputs don't-care, driven 0.
- Unrecognised instruction: enableOut=0, instFormat_o=0, body 0; pass-through fields still registered.
- A-format: primary 59 with bits 26:30 in {18,20,21,22,24,25,26,28,29,30,31} (11 ops); primary 63 with the same set plus 23 (12 ops). 23 total.
  - Unit FPU.
  - body[0:4]=FRT, [5:9]=FRA, [10:14]=FRB, [15:19]=FRC, [20]=Rc.
  - op1 write; op2/op3/op4 read.
  - Unused fields get rw=00, isReg=0: FRC for xo 18/20/21; FRB for xo 25; FRA and FRC for xo 22/24/26.
- B-format: primary 16 only (bc).
  - Unit branch.
  - body[0:4]=BO, [5:9]=BI, [10:23]=BD, [24]=AA, [25]=LK.
  - All ops isReg=0, rw=00.
- D-format: primary {2,3,7,8,10,11,12,13,14,15,24..29,32..55}. 40 total.
  - body[0:4]=bits 6:10 (op1), [5:9]=bits 11:15 (op2), [20:83]=64-bit immediate from D field (bits 16:31).
  - Immediate: sign-extended, except 10 and 24..29 zero-extended; 15/25/27/29 shifted left 16 (15 then sign-extended).
  - Units: 32..55 load/store; all others integer.
  - Loads (32,34,40,42,46,48,50): op1 write, op2 read.
  - Stores (36,38,44,47,52,54): op1 read, op2 read.
  - Update forms (odd opcodes in 33..55 except 47): op2 read+write.
  - Arithmetic (7,8,12,13,14,15): op1 write, op2 read.
  - Logical (24..29): op1 read, op2 write.
  - Compare/trap (2,3,10,11): op1 isReg=0 rw=00; op2 read.
  - op3 isReg=0, rw=00 (immediate); op4 unused, rw=00, isReg=0.
- Format decode ignores bits not named above. D/B decode is independent of bits 26:30.

Test Plan:
- Reset: drive reset_i=0 mid-operation -> all outputs 0 immediately; release, enable_i=0 -> enableOut=0.
- Sweep primary 0..63 × bits 26:30 0..31, enable_i=1 -> exactly 23 cycles with enableOut=1 and instFormat_o=512; e.g. 0xFC00002A (fadd) -> opcode {63,21}, unit 1.
- Sweep primary 0..63 with bits 26:30=31 -> exactly 1 B-format hit (opcode 16, instFormat_o=2, unit 2).
- Same sweep -> exactly 40 D-format hits (instFormat_o=32). 0x3860FFFF (addi r3,0,-1) -> body[20:83]=all ones, op1rw=write.
- Stall: hold stall_i=1 while changing instruction_i -> outputs unchanged. Release -> new decode appears after next edge.
- Pass-through: address 0x1000, majId 7, pid 3, tid 2 -> same values next cycle, minIDOut=0.
